ring_phase_decoder: RTL and testbench
=====================================

Name: ring_phase_decoder

Overview:
- Receiving-end companion to the team's right-shift one-hot ring counter.
- Samples a ring-counter phase bus and encodes the one-hot code to a binary index.
- Checks that each sample is a legal one-hot code and the correct next step of the rotation.
- Runs an acquire/lock state machine and reports errors to downstream control and status logic.

Parameters:
- WIDTH, 4, number of ring stages (phase_in width); legal range 2..16.
- LOCK_COUNT, 4, consecutive correct steps required to enter LOCKED; legal range 1..15.
- DIR, 0, expected rotation: 0 = right shift (next = {p[0],p[WIDTH-1:1]}, index decrements); 1 = left shift (index increments).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; phase_in is evaluated only in cycles where en=1.
- phase_in  input  WIDTH  one-hot phase bus from the ring counter.
- phase_idx  output  $clog2(WIDTH)  binary index of the set bit from the last legal sample (4'b1000 -> 3).
- valid  output  1  one-cycle pulse when phase_idx has been updated by a legal sample.
- locked  output  1  high while the FSM is in LOCKED.
- err_illegal  output  1  one-cycle pulse: sampled code is not one-hot (zero bits set, or more than one).
- err_seq  output  1  one-cycle pulse: code is legal but is not the expected successor.
- err_count  output  8  saturating count of error events.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM = SEARCH, step counter 0, expected index 0. Reset takes effect immediately, even mid-sequence.
- Latency: all outputs are registered, so a sample taken with en=1 in cycle N is reflected in cycle N+1.
- While en=0: state holds, phase_idx holds, and all pulses are 0.
- Legality: a sample is legal when exactly one bit of phase_in is set.
- Expected successor:
  - DIR=0: (idx-1) mod WIDTH, so 0 wraps to WIDTH-1.
  - DIR=1: (idx+1) mod WIDTH, so WIDTH-1 wraps to 0.
- FSM state SEARCH:
  - Legal sample: capture idx, valid=1, step counter = 1.
  - If LOCK_COUNT=1, go to LOCKED; otherwise go to ACQUIRE.
  - Illegal sample: err_illegal=1, stay in SEARCH.
- FSM state ACQUIRE:
  - Correct successor: valid=1, step counter +1. When the counter reaches LOCK_COUNT, go to LOCKED.
  - Legal but wrong successor: err_seq=1, valid=1, re-seed with the new idx, step counter = 1, stay in ACQUIRE.
  - Illegal sample: err_illegal=1, go to SEARCH, step counter = 0.
- FSM state LOCKED:
  - Correct successor: valid=1, locked stays 1.
  - Wrong successor: err_seq=1, valid=1, re-seed idx, go to ACQUIRE with step counter = 1. locked falls in the same cycle the error pulse appears.
  - Illegal sample: err_illegal=1, go to SEARCH; phase_idx holds its last legal value.
- Error priority: a sample is never flagged both ways. If it is illegal, only err_illegal pulses.
- err_count:
  - Increments by 1 for each err_illegal or err_seq pulse.
  - Saturates at 255.
  - Cleared only by reset.
- A repeated code (the same idx twice) counts as a sequence error.

Decomposition:
- Shared package ring_pkg holds:
  - FSM state enum: SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - Constant for the err_count width (8).
  - Function onehot_to_idx, which returns the index and a legal flag.
- One natural sub-module: onehot_encoder.
  - Purely combinational, parameterized by WIDTH.
  - Outputs idx and is_onehot.
  - Reusable by other ring/Johnson counter consumers.

Test Plan:
- Reset then a clean right-shift stream with en=1 every cycle (1000, 0100, 0010, 0001, 1000, ...), WIDTH=4, LOCK_COUNT=4:
  - phase_idx follows 3, 2, 1, 0, 3.
  - valid is high on each sample.
  - locked rises one cycle after the 4th sample.
  - No errors and err_count=0.
- While locked, inject 0110:
  - err_illegal pulses once and locked drops.
  - phase_idx holds its last legal value.
  - err_count=1.
  - Relock requires 4 clean samples.
- While locked, skip a step (0100 followed by 0001):
  - err_seq pulses and the FSM goes to ACQUIRE.
  - phase_idx=0.
  - Next 0000 gives err_illegal and the FSM goes to SEARCH; err_count=2.
- Toggle en (1 cycle on, 3 cycles off) while driving a clean sequence:
  - State and phase_idx advance only on strobe cycles.
  - No pulses in idle cycles.
  - Lock is reached after 4 strobes.
- Assert rst low asynchronously, between clock edges, while locked:
  - All outputs go to 0 immediately, without waiting for a clock.
  - After release, the first legal sample gives valid with locked=0.
- Drive 300 consecutive 0000 samples:
  - err_count saturates at 255.
  - err_illegal still pulses on every sample.
  - The FSM stays in SEARCH.

Source files
------------

// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared types and helpers for ring-counter phase consumers.
//               Holds the decoder FSM state encoding, the error-counter width
//               and a one-hot to binary conversion helper.
// Contents    : state_t        - decoder FSM states
//               c_ERR_W        - width of the saturating error counter
//               c_MAX_W        - widest ring the helper function accepts
//               onehot_res_t   - {legal, idx} result of onehot_to_idx
//               onehot_to_idx  - index of the set bit plus a one-hot flag
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int c_ERR_W = 8;
  localparam int c_MAX_W = 16;

  typedef struct packed {
    logic       legal;
    logic [3:0] idx;
  } onehot_res_t;

  // Narrower codes are zero-extended by the caller. The index reported is
  // the highest set bit; it is only meaningful when legal is set.
  function automatic onehot_res_t onehot_to_idx(input logic [c_MAX_W-1:0] code);
    onehot_res_t r;
    logic [4:0]  n_set;
    r.idx = 4'd0;
    n_set = 5'd0;
    for (int i = 0; i < c_MAX_W; i++) begin
      if (code[i]) begin
        r.idx = 4'(i);
        n_set = n_set + 5'd1;
      end
    end
    r.legal = (n_set == 5'd1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder
// Description : Combinational one-hot to binary encoder with legality flag.
//               Usable by any ring/Johnson counter consumer up to 16 stages.
// Ports       : phase     in  WIDTH          one-hot code to encode
//               idx       out $clog2(WIDTH)  index of the set bit
//               is_onehot out 1              exactly one bit of phase is set
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         phase,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     is_onehot
);

  localparam int IDX_W = $clog2(WIDTH);

  onehot_res_t w_res;

  always_comb begin
    w_res = onehot_to_idx(c_MAX_W'(phase));
  end

  assign idx = w_res.idx[IDX_W-1:0];
  // The index must also fit the ring; with zero-extended input this always
  // holds, but it keeps the flag honest if the helper is ever widened.
  assign is_onehot = w_res.legal && ((w_res.idx >> IDX_W) == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ring_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ring_phase_decoder
// Description : Receiving end of a one-hot ring counter. Encodes each strobed
//               sample to a binary index, checks it is one-hot and the expected
//               successor, and runs a SEARCH/ACQUIRE/LOCKED tracking FSM.
// Ports       : clk         in  1             rising-edge clock
//               rst         in  1             asynchronous reset, active low
//               en          in  1             sample strobe
//               phase_in    in  WIDTH         one-hot phase bus
//               phase_idx   out $clog2(WIDTH) index of last legal sample
//               valid       out 1             pulse: phase_idx updated
//               locked      out 1             FSM is in LOCKED
//               err_illegal out 1             pulse: sample not one-hot
//               err_seq     out 1             pulse: legal but wrong successor
//               err_count   out 8             saturating error event count
// Revision    : 1.0 - initial release
// ============================================================================
module ring_phase_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int DIR        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase_in,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic                     valid,
  output logic                     locked,
  output logic                     err_illegal,
  output logic                     err_seq,
  output logic [c_ERR_W-1:0]       err_count
);

  localparam int                 IDX_W     = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]   c_LAST    = IDX_W'(WIDTH - 1);
  localparam logic [3:0]         c_LOCK    = 4'(LOCK_COUNT);
  localparam logic [c_ERR_W-1:0] c_ERR_MAX = {c_ERR_W{1'b1}};

  state_t           r_state;
  logic [3:0]       r_step;

  logic [IDX_W-1:0] w_idx;
  logic             w_onehot;
  logic [IDX_W-1:0] w_succ;
  logic             w_match;
  logic [3:0]       w_step_inc;
  logic             w_err_evt;

  onehot_encoder #(
    .WIDTH(WIDTH)
  ) u_enc (
    .phase    (phase_in),
    .idx      (w_idx),
    .is_onehot(w_onehot)
  );

  // Expected successor of the last legal index, wrapping around the ring.
  always_comb begin
    w_succ = '0;
    if (DIR != 0) begin
      w_succ = (phase_idx == c_LAST) ? '0 : phase_idx + 1'b1;
    end else begin
      w_succ = (phase_idx == '0) ? c_LAST : phase_idx - 1'b1;
    end
  end

  assign w_match    = (w_idx == w_succ);
  assign w_step_inc = r_step + 4'd1;
  // Illegal codes always count; a sequence error needs a reference index,
  // which only exists outside SEARCH.
  assign w_err_evt  = en && (!w_onehot || ((r_state != SEARCH) && !w_match));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_step      <= 4'd0;
      phase_idx   <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_count   <= '0;
    end else begin
      valid       <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;

      if (w_err_evt && (err_count != c_ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end

      if (en) begin
        if (!w_onehot) begin
          // Illegal code: drop back to SEARCH, phase_idx keeps last legal value.
          err_illegal <= 1'b1;
          r_state     <= SEARCH;
          r_step      <= 4'd0;
          locked      <= 1'b0;
        end else begin
          valid     <= 1'b1;
          phase_idx <= w_idx;
          case (r_state)
            SEARCH: begin
              r_step <= 4'd1;
              if (LOCK_COUNT == 1) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end else begin
                r_state <= ACQUIRE;
              end
            end
            ACQUIRE: begin
              if (w_match) begin
                r_step <= w_step_inc;
                if (w_step_inc == c_LOCK) begin
                  r_state <= LOCKED;
                  locked  <= 1'b1;
                end
              end else begin
                err_seq <= 1'b1;
                r_step  <= 4'd1;
              end
            end
            LOCKED: begin
              if (!w_match) begin
                err_seq <= 1'b1;
                r_step  <= 4'd1;
                r_state <= ACQUIRE;
                locked  <= 1'b0;
              end
            end
            default: begin
              r_state <= SEARCH;
              r_step  <= 4'd0;
              locked  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_phase_decoder
// Description : Self-checking bench for ring_phase_decoder (WIDTH=4,
//               LOCK_COUNT=4, DIR=0). A streak-based reference model is
//               compared every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_phase_decoder;

  localparam int WIDTH      = 4;
  localparam int LOCK_COUNT = 4;
  localparam int DIR        = 0;
  localparam int IDX_W      = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] phase_in = '0;
  logic [IDX_W-1:0] phase_idx;
  logic             valid;
  logic             locked;
  logic             err_illegal;
  logic             err_seq;
  logic [7:0]       err_count;

  int n_cmp = 0;
  int n_bad = 0;

  ring_phase_decoder #(
    .WIDTH     (WIDTH),
    .LOCK_COUNT(LOCK_COUNT),
    .DIR       (DIR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .phase_in   (phase_in),
    .phase_idx  (phase_idx),
    .valid      (valid),
    .locked     (locked),
    .err_illegal(err_illegal),
    .err_seq    (err_seq),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks "have a reference index" and the length of the current run of
  // correct steps; locked simply means the run is at least LOCK_COUNT long.
  int m_idx    = 0;
  int m_streak = 0;
  int m_errs   = 0;
  bit m_ref    = 1'b0;
  bit e_valid  = 1'b0;
  bit e_ill    = 1'b0;
  bit e_seq    = 1'b0;

  function automatic int idx_of(input logic [WIDTH-1:0] p);
    return $clog2(int'(p));
  endfunction

  function automatic int succ_of(input int i);
    return (i + ((DIR != 0) ? 1 : WIDTH - 1)) % WIDTH;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx <= 0; m_streak <= 0; m_errs <= 0; m_ref <= 1'b0;
      e_valid <= 1'b0; e_ill <= 1'b0; e_seq <= 1'b0;
    end else begin
      e_valid <= 1'b0; e_ill <= 1'b0; e_seq <= 1'b0;
      if (en) begin
        if ($countones(phase_in) != 1) begin
          e_ill    <= 1'b1;
          m_ref    <= 1'b0;
          m_streak <= 0;
          m_errs   <= (m_errs < 255) ? m_errs + 1 : 255;
        end else begin
          e_valid <= 1'b1;
          m_idx   <= idx_of(phase_in);
          m_ref   <= 1'b1;
          if (m_ref && idx_of(phase_in) == succ_of(m_idx)) begin
            m_streak <= (m_streak < 1000) ? m_streak + 1 : m_streak;
          end else begin
            m_streak <= 1;
            if (m_ref) begin
              e_seq  <= 1'b1;
              m_errs <= (m_errs < 255) ? m_errs + 1 : 255;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model.phase_idx",   int'(phase_idx),   m_idx);
    chk("model.valid",       int'(valid),       int'(e_valid));
    chk("model.locked",      int'(locked),      (m_streak >= LOCK_COUNT) ? 1 : 0);
    chk("model.err_illegal", int'(err_illegal), int'(e_ill));
    chk("model.err_seq",     int'(err_seq),     int'(e_seq));
    chk("model.err_count",   int'(err_count),   m_errs);
  end

  // One strobed (or idle) sample; returns just after the edge that took it.
  task automatic cyc(input logic e, input logic [WIDTH-1:0] p);
    @(negedge clk);
    en       = e;
    phase_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.phase_idx", int'(phase_idx), 0);
    chk("reset.locked",    int'(locked),    0);
    chk("reset.valid",     int'(valid),     0);
    chk("reset.err_count", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Clean right-shift stream
    cyc(1'b1, 4'b1000); chk("s1.idx", int'(phase_idx), 3); chk("s1.valid", int'(valid), 1);
    cyc(1'b1, 4'b0100); chk("s2.idx", int'(phase_idx), 2);
    cyc(1'b1, 4'b0010); chk("s3.idx", int'(phase_idx), 1); chk("s3.locked", int'(locked), 0);
    cyc(1'b1, 4'b0001); chk("s4.idx", int'(phase_idx), 0); chk("s4.locked", int'(locked), 1);
    cyc(1'b1, 4'b1000); chk("s5.idx", int'(phase_idx), 3); chk("s5.errs", int'(err_count), 0);

    // Illegal injection while locked
    cyc(1'b1, 4'b0110);
    chk("ill.err_illegal", int'(err_illegal), 1);
    chk("ill.err_seq",     int'(err_seq),     0);
    chk("ill.locked",      int'(locked),      0);
    chk("ill.idx_hold",    int'(phase_idx),   3);
    chk("ill.errs",        int'(err_count),   1);

    // Relock needs four clean samples
    cyc(1'b1, 4'b0100);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0001); chk("relock3.locked", int'(locked), 0);
    cyc(1'b1, 4'b1000); chk("relock4.locked", int'(locked), 1);

    // Skipped step while locked
    cyc(1'b1, 4'b0100); chk("skip0.locked", int'(locked), 1);
    cyc(1'b1, 4'b0001);
    chk("skip.err_seq", int'(err_seq),   1);
    chk("skip.locked",  int'(locked),    0);
    chk("skip.idx",     int'(phase_idx), 0);
    chk("skip.valid",   int'(valid),     1);
    cyc(1'b1, 4'b0000);
    chk("zero.err_illegal", int'(err_illegal), 1);
    chk("zero.errs",        int'(err_count),   3);

    // Strobed sequence, idle cycles carry junk that must be ignored
    cyc(1'b1, 4'b1000); chk("en1.idx", int'(phase_idx), 3);
    repeat (3) cyc(1'b0, 4'b1111);
    chk("en1.idle_idx", int'(phase_idx), 3); chk("en1.idle_valid", int'(valid), 0);
    cyc(1'b1, 4'b0100); chk("en2.idx", int'(phase_idx), 2);
    repeat (3) cyc(1'b0, 4'b0000);
    cyc(1'b1, 4'b0010);
    repeat (3) cyc(1'b0, 4'b0110);
    chk("en3.locked", int'(locked), 0);
    cyc(1'b1, 4'b0001); chk("en4.locked", int'(locked), 1);
    repeat (3) cyc(1'b0, 4'b1000);
    chk("en4.idle_locked", int'(locked), 1); chk("en4.errs", int'(err_count), 3);

    // Asynchronous reset between edges while locked
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst.locked",    int'(locked),    0);
    chk("arst.idx",       int'(phase_idx), 0);
    chk("arst.err_count", int'(err_count), 0);
    chk("arst.valid",     int'(valid),     0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 4'b0010);
    chk("post.valid",  int'(valid),     1);
    chk("post.locked", int'(locked),    0);
    chk("post.idx",    int'(phase_idx), 1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) cyc(1'b1, 4'b0000);
    chk("sat.err_count",   int'(err_count),   255);
    chk("sat.err_illegal", int'(err_illegal), 1);
    chk("sat.locked",      int'(locked),      0);
    chk("sat.idx_hold",    int'(phase_idx),   1);

    cyc(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
